// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared FSM state encoding and BCD digit limits for the stopwatch.
//            LAP state exists only when STOPWATCH_LAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
`ifdef STOPWATCH_LAP_EN
    , ST_LAP  = 2'd3
`endif
  } state_t;

  localparam logic [3:0] c_digit_max          = 4'd9;
  localparam int         c_sec_tens_max_deflt = 5;

endpackage

`default_nettype wire

// File: rtl/stopwatch_bcd_digit.sv
// ============================================================================
// Module   : stopwatch_bcd_digit
// Purpose  : One BCD counter digit, 0..max, with a combinational carry so a
//            chain of digits ripples in a single cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] max,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] r_digit;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_digit <= 4'd0;
    end else if (en) begin
      r_digit <= (r_digit == max) ? 4'd0 : r_digit + 4'd1;
    end
  end

  assign digit = r_digit;
  assign carry = en && (r_digit == max);

endmodule

`default_nettype wire

// File: rtl/stopwatch_core.sv
// ============================================================================
// Module   : stopwatch_core
// Purpose  : Four-digit BCD stopwatch (SS.hh) with start/stop, pause/clear and
//            optional lap snapshot, enabled by defining STOPWATCH_LAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SEC_TENS_MAX = c_sec_tens_max_deflt
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear_lap,
  output logic [15:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);

  state_t      r_state;
  state_t      w_state_next;
  logic        w_run_or_lap;
  logic        w_count_en;
  logic        w_clr;
  logic [3:0]  w_en;
  logic [3:0]  w_carry;
  logic [3:0]  w_digit [4];
  logic [15:0] w_count;
  logic        r_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // start_stop is tested first everywhere so it wins over a same-cycle clear_lap
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start_stop) w_state_next = ST_RUN;
      ST_RUN: begin
        if (start_stop) w_state_next = ST_PAUSED;
`ifdef STOPWATCH_LAP_EN
        else if (clear_lap) w_state_next = ST_LAP;
`endif
      end
      ST_PAUSED: begin
        if (start_stop)     w_state_next = ST_RUN;
        else if (clear_lap) w_state_next = ST_IDLE;
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (start_stop)     w_state_next = ST_PAUSED;
        else if (clear_lap) w_state_next = ST_RUN;
      end
`endif
      default:   w_state_next = ST_IDLE;
    endcase
  end

`ifdef STOPWATCH_LAP_EN
  assign w_run_or_lap = (r_state == ST_RUN) || (r_state == ST_LAP);
`else
  assign w_run_or_lap = (r_state == ST_RUN);
`endif

  assign w_count_en = tick && w_run_or_lap;
  assign w_clr      = (r_state == ST_PAUSED) && clear_lap && !start_stop;
  assign w_en       = {w_carry[2:0], w_count_en};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] c_max = (gi == 3) ? 4'(SEC_TENS_MAX) : c_digit_max;
      stopwatch_bcd_digit u_digit (
        .clk   (clk),
        .reset (reset),
        .en    (w_en[gi]),
        .clr   (w_clr),
        .max   (c_max),
        .digit (w_digit[gi]),
        .carry (w_carry[gi])
      );
    end
  endgenerate

  assign w_count = {w_digit[3], w_digit[2], w_digit[1], w_digit[0]};

  // Top-digit carry fires exactly when the whole count rolls over to 00.00
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_carry[3];
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [15:0] r_snap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap <= 16'h0000;
    end else if ((r_state == ST_RUN) && clear_lap && !start_stop) begin
      r_snap <= w_count;
    end
  end

  assign disp       = (r_state == ST_LAP) ? r_snap : w_count;
  assign lap_active = (r_state == ST_LAP);
`else
  assign disp       = w_count;
  assign lap_active = 1'b0;
`endif

  assign running = w_run_or_lap;
  assign wrap    = r_wrap;

endmodule

`default_nettype wire

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter SEC_TENS_MAX, default 5, meaning the largest seconds-tens digit before wrap (5 gives a 59.99 s range).
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-003 SHALL have port reset  input  1  reset: synchronous, active-high; clock clk.
REQ-004 SHALL have port tick  input  1  one-cycle pulse every 10 ms from the clock divider.
REQ-005 SHALL have port start_stop  input  1  one-cycle debounced button pulse.
REQ-006 SHALL have port clear_lap  input  1  one-cycle debounced button pulse.
REQ-007 SHALL have port disp  output  16  BCD display digits {sec tens, sec ones, tenths, hundredths}, [15:12] down to [3:0].
REQ-008 SHALL have port running  output  1  high when the state is RUN or LAP.
REQ-009 SHALL have port lap_active  output  1  high when the state is LAP.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse when the count rolls from the maximum to 00.00.

Function
REQ-011 SHALL implement the states IDLE, RUN, PAUSED and LAP, all registered.
REQ-012 SHALL apply these transitions: IDLE+start_stop->RUN; RUN+start_stop->PAUSED; RUN+clear_lap->LAP; LAP+clear_lap->RUN; LAP+start_stop->PAUSED; PAUSED+start_stop->RUN; PAUSED+clear_lap->IDLE; every other event is ignored.
REQ-013 SHALL give start_stop priority when both pulses arrive in the same cycle; clear_lap is then dropped.
REQ-014 SHALL increment the count by 0.01 s on the clock edge that samples tick=1 when the registered state is RUN or LAP, so the count is visible one cycle after the tick.
REQ-015 SHALL count a tick that coincides with a RUN->PAUSED transition, and SHALL NOT count a tick that coincides with an IDLE->RUN or PAUSED->RUN transition.
REQ-016 SHALL keep each digit in the range 0-9, except sec tens, which stays in 0..SEC_TENS_MAX; carries ripple within the same cycle.
REQ-017 SHALL roll the count from SEC_TENS_MAX9.99 to 00.00 on a counted tick and pulse wrap for exactly one cycle, coincident with the 00.00 value.
REQ-018 SHALL zero the count on the PAUSED->IDLE edge; the count holds in IDLE and PAUSED.
REQ-019 SHALL drive disp from the live count in IDLE, RUN and PAUSED, and from the lap snapshot in LAP.
REQ-020 SHALL load the lap snapshot on the RUN->LAP edge with the current count register value, excluding any same-cycle tick increment.
REQ-021 SHALL switch disp back to the live count in the cycle after LAP->PAUSED or LAP->RUN.

Reset
REQ-022 SHALL, on reset, set the state to IDLE, the count and snapshot to 0, disp=16'h0000, running=0, lap_active=0 and wrap=0.
REQ-023 SHALL give reset priority over tick and both buttons, including when reset is asserted mid-run or in the wrap cycle.

Configuration
REQ-024 SHALL, with STOPWATCH_LAP_EN defined, implement the LAP state and the snapshot register as described above.
REQ-025 SHALL, without STOPWATCH_LAP_EN, omit the LAP state and snapshot, ignore clear_lap in RUN, tie lap_active to 0, and leave every other behaviour unchanged.

Structure
REQ-026 SHALL place the state enum typedef and the digit-limit constants (9, default SEC_TENS_MAX) in the shared package stopwatch_pkg.
REQ-027 SHALL build the count from a chain of sub-module stopwatch_bcd_digit (inputs: en, clr, max; outputs: digit, carry), instanced once per digit.

Verification
REQ-028 SHALL verify the basic count: reset, start_stop, then 150 ticks -> disp=16'h0150, running=1.
REQ-029 SHALL verify wrap: reach 59.99, then 1 tick -> disp=16'h0000 and wrap high for exactly 1 cycle.
REQ-030 SHALL verify the lap snapshot: at 12.34 pulse clear_lap, then 100 ticks -> disp holds 16'h1234 while the live count reaches 13.34; clear_lap again -> disp=16'h1334 the next cycle.
REQ-031 SHALL verify pause and clear: at 00.07 pulse start_stop, then 20 ticks -> disp stays 16'h0007; clear_lap -> IDLE with disp=16'h0000.
REQ-032 SHALL verify simultaneous events: start_stop and clear_lap in the same cycle while in RUN -> PAUSED, not LAP; tick on the IDLE->RUN edge -> count stays 00.00.
REQ-033 SHALL verify reset mid-run: assert reset at 03.21 in LAP -> all outputs 0 and state IDLE on the next edge.
